// File: rtl/rv32i_types.sv
// Shared type package for the rv32i memory subsystem.
// Holds the arbiter state enum and the constants the arbiter uses when it
// builds the physical-memory request.
package rv32i_types;

  // Arbiter states: IDLE evaluates requests, I_BUSY/D_BUSY hold the pmem
  // strobe for the granted client, DONE pulses that client's resp.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_I_BUSY = 2'd1,
    ARB_D_BUSY = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  // Reads always fetch the whole word.
  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arbiter_arb_req_reg.sv
// arb_req_reg: holding register for the granted memory request.
// Captures address, write data, byte enable and the read/write operation on
// load; holds them for the rest of the transaction so pmem_* never follow
// the client inputs.
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears all)
//   load                 capture the *_in values this cycle
//   address_in/wdata_in  32-bit request address / write data
//   byte_enable_in       4-bit byte enable
//   read_in/write_in     operation (mutually exclusive, chosen by the FSM)
//   address/wdata/byte_enable/read/write  latched copies
module arb_req_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] address_in,
  input  logic [31:0] wdata_in,
  input  logic [3:0]  byte_enable_in,
  input  logic        read_in,
  input  logic        write_in,
  output logic [31:0] address,
  output logic [31:0] wdata,
  output logic [3:0]  byte_enable,
  output logic        read,
  output logic        write
);

  always_ff @(posedge clk) begin
    if (rst) begin
      address     <= 32'h0;
      wdata       <= 32'h0;
      byte_enable <= 4'h0;
      read        <= 1'b0;
      write       <= 1'b0;
    end else if (load) begin
      address     <= address_in;
      wdata       <= wdata_in;
      byte_enable <= byte_enable_in;
      read        <= read_in;
      write       <= write_in;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between the instruction
// fetch client (imem) and the data client (dmem).
// Handshake: a client holds read/write high to request; the arbiter answers
// with a one-cycle resp pulse, rdata valid in that same cycle. Towards pmem,
// read/write stay high from the cycle after the grant until the cycle in
// which pmem_resp is sampled high; pmem_resp is a one-cycle pulse.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_read, imem_address           fetch request
//   imem_resp, imem_rdata             fetch completion / data
//   dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable
//                                     data request
//   dmem_resp, dmem_rdata             data completion / read data
//   pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
//                                     physical memory request
//   pmem_rdata, pmem_resp             physical memory completion
module mem_arbiter
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read,
  input  logic [31:0] imem_address,
  output logic        imem_resp,
  output logic [31:0] imem_rdata,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_byte_enable,
  output logic        dmem_resp,
  output logic [31:0] dmem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_byte_enable,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  arb_state_t  state, state_next;
  // Set on a data grant, cleared on a fetch grant. During DONE it also
  // names the client that owns the finishing transaction.
  logic        last_grant_data;
  logic        grant_d, grant_i, busy;
  logic [31:0] req_address, req_wdata;
  logic [3:0]  req_byte_enable;
  logic        req_read, req_write;

  // Data wins a tie unless it also won last time (fetch must not starve).
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == ARB_IDLE) begin
      grant_d = (dmem_read | dmem_write) & ~(imem_read & last_grant_data);
      grant_i = imem_read & ~grant_d;
    end
  end

  assign busy = (state == ARB_I_BUSY) || (state == ARB_D_BUSY);

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (grant_d)      state_next = ARB_D_BUSY;
        else if (grant_i) state_next = ARB_I_BUSY;
      end
      ARB_I_BUSY, ARB_D_BUSY: if (pmem_resp) state_next = ARB_DONE;
      default:          state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ARB_IDLE;
      last_grant_data <= 1'b0;
      imem_rdata      <= 32'h0;
      dmem_rdata      <= 32'h0;
    end else begin
      state <= state_next;
      if (grant_d)      last_grant_data <= 1'b1;
      else if (grant_i) last_grant_data <= 1'b0;
      if (state == ARB_D_BUSY && pmem_resp) dmem_rdata <= pmem_rdata;
      if (state == ARB_I_BUSY && pmem_resp) imem_rdata <= pmem_rdata;
    end
  end

  // A simultaneous read+write from the data side is issued as a write.
  arb_req_reg u_req (
    .clk            (clk),
    .rst            (rst),
    .load           (grant_d | grant_i),
    .address_in     (grant_d ? dmem_address : imem_address),
    .wdata_in       (grant_d ? dmem_wdata : 32'h0),
    .byte_enable_in (grant_d ? dmem_byte_enable : BE_FULL),
    .read_in        (grant_d ? (dmem_read & ~dmem_write) : 1'b1),
    .write_in       (grant_d & dmem_write),
    .address        (req_address),
    .wdata          (req_wdata),
    .byte_enable    (req_byte_enable),
    .read           (req_read),
    .write          (req_write)
  );

  assign pmem_read        = busy & req_read;
  assign pmem_write       = busy & req_write;
  assign pmem_address     = req_address;
  assign pmem_wdata       = req_wdata;
  assign pmem_byte_enable = req_write ? req_byte_enable : BE_FULL;

  assign imem_resp = (state == ARB_DONE) & ~last_grant_data;
  assign dmem_resp = (state == ARB_DONE) &  last_grant_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a task-driven pmem responder plus one task
// per scenario with inline expected values.
module tb_mem_arbiter;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_read = 1'b0;
  logic [31:0] imem_address = 32'h0;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        dmem_read = 1'b0, dmem_write = 1'b0;
  logic [31:0] dmem_address = 32'h0, dmem_wdata = 32'h0;
  logic [3:0]  dmem_byte_enable = 4'h0;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_rdata = 32'h0;
  logic        pmem_resp = 1'b0;

  int checks = 0;
  int errors = 0;
  int i_cnt = 0, d_cnt = 0, overlap_cnt = 0;
  int i0, d0;

  // results of the last serve() call
  int          s_rd, s_wr, s_wait;
  logic        s_stable, s_timeout;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // clock / reset
  always #5 clk = ~clk;

  // resp pulse counters and exclusivity monitor
  always @(negedge clk) begin
    if (imem_resp) i_cnt++;
    if (dmem_resp) d_cnt++;
    if ((imem_resp && dmem_resp) || (pmem_read && pmem_write)) overlap_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time got %0t want < 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // pmem driver: waits (bounded) for a strobe, answers in the lat-th strobe
  // cycle with rd, returns in the DONE cycle. chg != 0 rewrites the client
  // addresses during the first strobe cycle.
  task serve(input int lat, input logic [31:0] rd, input logic [31:0] chg);
    s_rd = 0; s_wr = 0; s_wait = 0; s_stable = 1'b1; s_timeout = 1'b0;
    do begin
      tick();
      s_wait++;
    end while (!(pmem_read || pmem_write) && s_wait < 20);
    if (!(pmem_read || pmem_write)) begin
      s_timeout = 1'b1;
      return;
    end
    s_addr = pmem_address; s_wdata = pmem_wdata; s_be = pmem_byte_enable;
    if (chg != 32'h0) begin
      imem_address = chg;
      dmem_address = chg;
    end
    for (int n = 1; n <= lat; n++) begin
      if (n > 1) tick();
      if (pmem_address !== s_addr || pmem_wdata !== s_wdata ||
          pmem_byte_enable !== s_be) s_stable = 1'b0;
      if (pmem_read)  s_rd++;
      if (pmem_write) s_wr++;
      if (n == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
      end
    end
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = 32'hBAD0_BAD0;
  endtask

  task test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++; if (dut.state !== ARB_IDLE) begin errors++; $display("FAIL rst_state got %0d want %0d", dut.state, ARB_IDLE); end
    checks++; if ({pmem_read, pmem_write, imem_resp, dmem_resp} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b want 0000", {pmem_read, pmem_write, imem_resp, dmem_resp}); end
    checks++; if (imem_rdata !== 32'h0 || dmem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h want 0/0", imem_rdata, dmem_rdata); end
    checks++; if (pmem_address !== 32'h0 || pmem_wdata !== 32'h0) begin errors++; $display("FAIL rst_latched got %h/%h want 0/0", pmem_address, pmem_wdata); end
    rst = 1'b0;
  endtask

  task test_fetch;
    imem_read = 1'b1; imem_address = 32'h60;
    i0 = i_cnt; d0 = d_cnt;
    serve(3, 32'h0000_0013, 32'h0);
    checks++; if (s_timeout !== 1'b0) begin errors++; $display("FAIL fetch_timeout got %b want 0", s_timeout); end
    checks++; if (s_wait !== 1) begin errors++; $display("FAIL fetch_latency got %0d want 1", s_wait); end
    checks++; if (s_rd !== 3 || s_wr !== 0) begin errors++; $display("FAIL fetch_strobes got rd%0d wr%0d want rd3 wr0", s_rd, s_wr); end
    checks++; if (s_addr !== 32'h60 || s_be !== 4'hF) begin errors++; $display("FAIL fetch_addr got %h/%h want 60/f", s_addr, s_be); end
    checks++; if (imem_resp !== 1'b1 || dmem_resp !== 1'b0) begin errors++; $display("FAIL fetch_resp got %b%b want 10", imem_resp, dmem_resp); end
    checks++; if (imem_rdata !== 32'h13) begin errors++; $display("FAIL fetch_rdata got %h want 00000013", imem_rdata); end
    checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin errors++; $display("FAIL done_strobes got %b%b want 00", pmem_read, pmem_write); end
    imem_read = 1'b0;
    tick();
    checks++; if (dut.state !== ARB_IDLE || imem_resp !== 1'b0) begin errors++; $display("FAIL fetch_return got %0d/%b want %0d/0", dut.state, imem_resp, ARB_IDLE); end
    checks++; if (imem_rdata !== 32'h13) begin errors++; $display("FAIL fetch_hold got %h want 00000013", imem_rdata); end
    checks++; if (i_cnt - i0 !== 1 || d_cnt - d0 !== 0) begin errors++; $display("FAIL fetch_pulses got i%0d d%0d want i1 d0", i_cnt - i0, d_cnt - d0); end
  endtask

  task test_simultaneous;
    dmem_read = 1'b1; dmem_address = 32'h100;
    imem_read = 1'b1; imem_address = 32'h64;
    serve(1, 32'h1111_1111, 32'h0);
    checks++; if (s_timeout !== 1'b0 || s_addr !== 32'h100) begin errors++; $display("FAIL tie1_grant got %h (to %b) want 00000100", s_addr, s_timeout); end
    checks++; if (s_rd !== 1 || s_be !== 4'hF || s_wait !== 1) begin errors++; $display("FAIL tie1_shape got rd%0d be%h wait%0d want rd1 bef wait1", s_rd, s_be, s_wait); end
    checks++; if (dmem_resp !== 1'b1 || imem_resp !== 1'b0 || dmem_rdata !== 32'h1111_1111) begin errors++; $display("FAIL tie1_resp got %b%b %h want 10 11111111", dmem_resp, imem_resp, dmem_rdata); end
    serve(1, 32'h2222_2222, 32'h0);
    checks++; if (s_timeout !== 1'b0 || s_addr !== 32'h64) begin errors++; $display("FAIL tie2_grant got %h (to %b) want 00000064", s_addr, s_timeout); end
    checks++; if (s_wait !== 2) begin errors++; $display("FAIL tie2_regrant got %0d want 2", s_wait); end
    checks++; if (imem_resp !== 1'b1 || dmem_resp !== 1'b0 || imem_rdata !== 32'h2222_2222) begin errors++; $display("FAIL tie2_resp got %b%b %h want 10 22222222", imem_resp, dmem_resp, imem_rdata); end
    serve(1, 32'h3333_3333, 32'h0);
    checks++; if (s_timeout !== 1'b0 || s_addr !== 32'h100) begin errors++; $display("FAIL tie3_grant got %h (to %b) want 00000100", s_addr, s_timeout); end
    checks++; if (dmem_rdata !== 32'h3333_3333 || imem_rdata !== 32'h2222_2222) begin errors++; $display("FAIL tie3_rdata got %h/%h want 33333333/22222222", dmem_rdata, imem_rdata); end
    dmem_read = 1'b0; imem_read = 1'b0;
    tick();
  endtask

  task test_store;
    dmem_write = 1'b1; dmem_address = 32'h104;
    dmem_wdata = 32'hDEAD_BEEF; dmem_byte_enable = 4'h4;
    d0 = d_cnt;
    serve(2, 32'h0, 32'h0);
    checks++; if (s_timeout !== 1'b0 || s_wr !== 2 || s_rd !== 0) begin errors++; $display("FAIL store_strobes got wr%0d rd%0d want wr2 rd0", s_wr, s_rd); end
    checks++; if (s_addr !== 32'h104 || s_wdata !== 32'hDEAD_BEEF || s_be !== 4'h4) begin errors++; $display("FAIL store_fields got %h %h %h want 00000104 deadbeef 4", s_addr, s_wdata, s_be); end
    checks++; if (dmem_resp !== 1'b1) begin errors++; $display("FAIL store_resp got %b want 1", dmem_resp); end
    dmem_read = 1'b1; dmem_address = 32'h108;
    dmem_wdata = 32'h1234_5678; dmem_byte_enable = 4'h3;
    serve(1, 32'h0, 32'h0);
    checks++; if (s_timeout !== 1'b0 || s_wr !== 1 || s_rd !== 0) begin errors++; $display("FAIL rw_strobes got wr%0d rd%0d want wr1 rd0", s_wr, s_rd); end
    checks++; if (s_addr !== 32'h108 || s_be !== 4'h3 || s_wait !== 2) begin errors++; $display("FAIL rw_fields got %h %h w%0d want 00000108 3 w2", s_addr, s_be, s_wait); end
    dmem_read = 1'b0; dmem_write = 1'b0;
    tick();
    checks++; if (d_cnt - d0 !== 2) begin errors++; $display("FAIL store_pulses got %0d want 2", d_cnt - d0); end
  endtask

  task test_mid_change;
    imem_read = 1'b1; imem_address = 32'h60;
    serve(3, 32'h0000_0013, 32'h80);
    checks++; if (s_timeout !== 1'b0 || s_addr !== 32'h60 || s_stable !== 1'b1) begin errors++; $display("FAIL mid_addr got %h stable%b want 00000060 stable1", s_addr, s_stable); end
    checks++; if (imem_resp !== 1'b1 || s_rd !== 3) begin errors++; $display("FAIL mid_resp got %b rd%0d want 1 rd3", imem_resp, s_rd); end
    imem_read = 1'b0;
    tick();
  endtask

  task test_reset_mid;
    dmem_read = 1'b1; dmem_address = 32'h200;
    d0 = d_cnt;
    tick();
    checks++; if (dut.state !== ARB_D_BUSY || pmem_read !== 1'b1) begin errors++; $display("FAIL rmid_busy got %0d/%b want %0d/1", dut.state, pmem_read, ARB_D_BUSY); end
    rst = 1'b1; dmem_read = 1'b0;
    tick();
    rst = 1'b0; pmem_resp = 1'b1; pmem_rdata = 32'h5555_5555;
    tick();
    pmem_resp = 1'b0;
    checks++; if (dut.state !== ARB_IDLE) begin errors++; $display("FAIL rmid_state got %0d want %0d", dut.state, ARB_IDLE); end
    checks++; if ({pmem_read, pmem_write, dmem_resp} !== 3'b0 || dmem_rdata !== 32'h0) begin errors++; $display("FAIL rmid_outputs got %b %h want 000 00000000", {pmem_read, pmem_write, dmem_resp}, dmem_rdata); end
    tick();
    checks++; if (d_cnt - d0 !== 0) begin errors++; $display("FAIL rmid_pulses got %0d want 0", d_cnt - d0); end
  endtask

  task test_held;
    dmem_read = 1'b1; dmem_address = 32'h300;
    d0 = d_cnt;
    serve(2, 32'h7777_7777, 32'h0);
    checks++; if (s_timeout !== 1'b0 || dmem_resp !== 1'b1 || dmem_rdata !== 32'h7777_7777) begin errors++; $display("FAIL held_first got %b %h want 1 77777777", dmem_resp, dmem_rdata); end
    tick();
    checks++; if (dut.state !== ARB_IDLE || dmem_resp !== 1'b0 || pmem_read !== 1'b0) begin errors++; $display("FAIL held_idle got %0d %b %b want %0d 0 0", dut.state, dmem_resp, pmem_read, ARB_IDLE); end
    serve(1, 32'h8888_8888, 32'h0);
    checks++; if (s_timeout !== 1'b0 || s_wait !== 1 || dmem_rdata !== 32'h8888_8888) begin errors++; $display("FAIL held_second got w%0d %h want w1 88888888", s_wait, dmem_rdata); end
    dmem_read = 1'b0;
    tick();
    checks++; if (d_cnt - d0 !== 2) begin errors++; $display("FAIL held_pulses got %0d want 2", d_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_mid_change();
    test_reset_mid();
    test_held();
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL exclusive got %0d want 0", overlap_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
